// File: rtl/program_sequencer_stack.sv
// program_sequencer_stack
//   Generates the program-memory fetch address every cycle. The jump target is
//   assembled from NUM_SEGS loadable segments. A call/return stack holds
//   STACK_DEPTH return addresses, with sticky overflow and underflow flags.
//
//   Optional feature macro: PS_TRAP_EN. When it is defined, an overflowing call
//   or an underflowing ret redirects the fetch to TRAP_ADDR and pulses trap.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   stall                 re-issue the current address; pc/stack/flags hold
//   jmp, jmp_nz, dont_jmp unconditional jump / jump taken when dont_jmp=0
//   call, ret             push pc+1 and jump / pop into pm_addr
//   seg_load, seg_sel,    write jmp_addr into a target segment; the value is
//   jmp_addr              also forwarded into the target in the same cycle
//   err_clr               clear stack_ovf / stack_unf
//   pm_addr               combinational fetch address (ROM registers it)
//   pc                    registered copy of pm_addr
//   sp                    stack occupancy
//   stack_ovf, stack_unf  sticky stack error flags
//   trap                  combinational trap-redirect pulse

module program_sequencer_stack #(
  parameter int unsigned SEG_WIDTH   = 4,
  parameter int unsigned NUM_SEGS    = 2,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [SEG_WIDTH*NUM_SEGS-1:0] TRAP_ADDR = 8'hF0,
  localparam int unsigned ADDR_WIDTH = SEG_WIDTH * NUM_SEGS,
  localparam int unsigned SEL_WIDTH  = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1,
  localparam int unsigned SP_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  jmp,
  input  logic                  jmp_nz,
  input  logic                  dont_jmp,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  seg_load,
  input  logic [SEL_WIDTH-1:0]  seg_sel,
  input  logic [SEG_WIDTH-1:0]  jmp_addr,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [SP_WIDTH-1:0]   sp,
  output logic                  stack_ovf,
  output logic                  stack_unf,
  output logic                  trap
);

  localparam int unsigned IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic                  start_q;
  logic [SEG_WIDTH-1:0]  seg_q   [NUM_SEGS];
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] tgt;
  logic [IDX_WIDTH-1:0]  push_idx;
  logic [IDX_WIDTH-1:0]  pop_idx;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  push;
  logic                  pop;
  logic                  set_ovf;
  logic                  set_unf;

  assign pc_inc      = pc + ADDR_WIDTH'(1);
  assign push_idx    = IDX_WIDTH'(sp);
  assign pop_idx     = IDX_WIDTH'(sp - SP_WIDTH'(1));
  assign stack_full  = (sp == SP_WIDTH'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

`ifndef PS_TRAP_EN
  // TRAP_ADDR has no consumer in this build.
  logic unused_trap_addr;
  assign unused_trap_addr = ^TRAP_ADDR;
`endif

  // Jump target: segment regs concatenated, with a same-cycle segment write forwarded.
  always_comb begin
    tgt = '0;
    for (int unsigned i = 0; i < NUM_SEGS; i++) begin
      if (seg_load && (seg_sel == SEL_WIDTH'(i))) begin
        tgt[i*SEG_WIDTH +: SEG_WIDTH] = jmp_addr;
      end else begin
        tgt[i*SEG_WIDTH +: SEG_WIDTH] = seg_q[i];
      end
    end
  end

  // Fetch-address priority and stack/flag actions for this cycle.
  always_comb begin
    pm_addr = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    trap    = 1'b0;
    if (start_q) begin
      pm_addr = '0;
    end else if (stall) begin
      pm_addr = pc;
    end else if (ret) begin
      // ret beats a simultaneous call; the call is simply dropped.
      if (stack_empty) begin
        set_unf = 1'b1;
`ifdef PS_TRAP_EN
        pm_addr = TRAP_ADDR;
        trap    = 1'b1;
`else
        pm_addr = pc_inc;
`endif
      end else begin
        pop     = 1'b1;
        pm_addr = stack_q[pop_idx];
      end
    end else if (call) begin
      if (stack_full) begin
        set_ovf = 1'b1;
`ifdef PS_TRAP_EN
        pm_addr = TRAP_ADDR;
        trap    = 1'b1;
`else
        pm_addr = tgt;
`endif
      end else begin
        push    = 1'b1;
        pm_addr = tgt;
      end
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pm_addr = tgt;
    end
  end

  // Control state: start flag, pc, stack pointer, segments, sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q   <= 1'b1;
      pc        <= '0;
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
      for (int unsigned i = 0; i < NUM_SEGS; i++) begin
        seg_q[i] <= '0;
      end
    end else begin
      start_q <= 1'b0;
      // During start pm_addr is 0, so pc also lands on 0.
      if (start_q || !stall) begin
        pc <= pm_addr;
      end
      if (!start_q && seg_load) begin
        for (int unsigned i = 0; i < NUM_SEGS; i++) begin
          if (seg_sel == SEL_WIDTH'(i)) begin
            seg_q[i] <= jmp_addr;
          end
        end
      end
      if (push) begin
        sp <= sp + SP_WIDTH'(1);
      end else if (pop) begin
        sp <= sp - SP_WIDTH'(1);
      end
      // A new error in the clearing cycle keeps the flag set.
      if (set_ovf) begin
        stack_ovf <= 1'b1;
      end else if (err_clr && !start_q && !stall) begin
        stack_ovf <= 1'b0;
      end
      if (set_unf) begin
        stack_unf <= 1'b1;
      end else if (err_clr && !start_q && !stall) begin
        stack_unf <= 1'b0;
      end
    end
  end

  // Return-address storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed bench for program_sequencer_stack (default parameters).
// A queue-based reference model is compared against the DUT on every falling
// edge; literal checks pin the expected addresses at key points.

module tb_program_sequencer_stack;

  localparam int MASK  = 255;
  localparam int DEPTH = 4;
  localparam int TRAPV = 'hF0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       stall, jmp, jmp_nz, dont_jmp, call, ret, seg_load, err_clr;
  logic [0:0] seg_sel;
  logic [3:0] jmp_addr;
  logic [7:0] pm_addr, pc;
  logic [2:0] sp;
  logic       stack_ovf, stack_unf, trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_sequencer_stack dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .stall    (stall),
    .jmp      (jmp),
    .jmp_nz   (jmp_nz),
    .dont_jmp (dont_jmp),
    .call     (call),
    .ret      (ret),
    .seg_load (seg_load),
    .seg_sel  (seg_sel),
    .jmp_addr (jmp_addr),
    .err_clr  (err_clr),
    .pm_addr  (pm_addr),
    .pc       (pc),
    .sp       (sp),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf),
    .trap     (trap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model state
  int  m_pc;
  int  m_seg[2];
  int  m_stack[$];
  bit  m_start, m_ovf, m_unf;

  always @(negedge clk) begin
    int e_pm, tg;
    bit e_trap, do_push, do_pop, s_ovf, s_unf;
    if (!reset_n) begin
      m_pc = 0; m_seg[0] = 0; m_seg[1] = 0; m_stack.delete();
      m_start = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
      check("rst_pm_addr", pm_addr, 0);
      check("rst_pc", pc, 0);
      check("rst_sp", sp, 0);
      check("rst_stack_ovf", stack_ovf, 0);
      check("rst_stack_unf", stack_unf, 0);
      check("rst_trap", trap, 0);
    end else begin
      e_trap = 0; do_push = 0; do_pop = 0; s_ovf = 0; s_unf = 0;
      tg = m_seg[1] * 16 + m_seg[0];
      if (seg_load) begin
        if (seg_sel == 1'b1) tg = int'(jmp_addr) * 16 + m_seg[0];
        else                 tg = m_seg[1] * 16 + int'(jmp_addr);
      end
      if (m_start) e_pm = 0;
      else if (stall) e_pm = m_pc;
      else if (ret) begin
        if (m_stack.size() == 0) begin
          s_unf = 1;
`ifdef PS_TRAP_EN
          e_pm = TRAPV; e_trap = 1;
`else
          e_pm = (m_pc + 1) & MASK;
`endif
        end else begin
          e_pm = m_stack[$]; do_pop = 1;
        end
      end else if (call) begin
        if (m_stack.size() == DEPTH) begin
          s_ovf = 1;
`ifdef PS_TRAP_EN
          e_pm = TRAPV; e_trap = 1;
`else
          e_pm = tg;
`endif
        end else begin
          e_pm = tg; do_push = 1;
        end
      end else if (jmp || (jmp_nz && !dont_jmp)) e_pm = tg;
      else e_pm = (m_pc + 1) & MASK;

      check("pm_addr", pm_addr, e_pm);
      check("pc", pc, m_pc);
      check("sp", sp, m_stack.size());
      check("stack_ovf", stack_ovf, m_ovf);
      check("stack_unf", stack_unf, m_unf);
      check("trap", trap, e_trap);

      if (!m_start) begin
        if (seg_load) m_seg[seg_sel] = int'(jmp_addr);
        if (!stall) begin
          if (do_push) m_stack.push_back((m_pc + 1) & MASK);
          if (do_pop) void'(m_stack.pop_back());
          if (s_ovf) m_ovf = 1; else if (err_clr) m_ovf = 0;
          if (s_unf) m_unf = 1; else if (err_clr) m_unf = 0;
          m_pc = e_pm;
        end
      end else begin
        m_pc = 0;
      end
      m_start = 0;
    end
  end

  task automatic idle();
    stall = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0; call = 0; ret = 0;
    seg_load = 0; err_clr = 0; seg_sel = '0; jmp_addr = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic seg(input logic s, input logic [3:0] v);
    seg_load = 1; seg_sel = s; jmp_addr = v;
  endtask

  initial begin
    idle();
    reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pm", pm_addr, 0); check("reset_sp", sp, 0); check("reset_pc", pc, 0);
    nxt(); reset_n = 1;
    @(negedge clk); check("start_pm", pm_addr, 0);
    nxt(); @(negedge clk); check("seq_pm1", pm_addr, 1); check("seq_pc0", pc, 0);
    nxt(); @(negedge clk); check("seq_pm2", pm_addr, 2); check("seq_pc1", pc, 1);
    nxt(); @(negedge clk); check("seq_pm3", pm_addr, 3); check("seq_pc2", pc, 2); check("seq_sp", sp, 0);

    // Segment forwarding
    nxt(); seg(1, 4'hA);
    nxt(); seg(0, 4'h5); jmp = 1;
    @(negedge clk); check("fwd_pm", pm_addr, 'hA5);
    nxt(); @(negedge clk); check("fwd_next_pm", pm_addr, 'hA6);

    // Call from 0x10 to 0x40, return from 0x47
    nxt(); seg(1, 4'h1);
    nxt(); seg(0, 4'h0); jmp = 1;
    @(negedge clk); check("jmp10_pm", pm_addr, 'h10);
    nxt(); seg(1, 4'h4); call = 1;
    @(negedge clk); check("call_pm", pm_addr, 'h40);
    nxt(); @(negedge clk); check("call_sp", sp, 1); check("call_next_pm", pm_addr, 'h41);
    repeat (6) nxt();
    nxt(); ret = 1;
    @(negedge clk); check("ret_pc", pc, 'h47); check("ret_pm", pm_addr, 'h11);
    nxt(); @(negedge clk); check("ret_sp", sp, 0); check("ret_next_pm", pm_addr, 'h12);

    // Overflow on the fifth call
    for (int i = 0; i < 4; i++) begin nxt(); call = 1; end
    nxt(); call = 1;
    @(negedge clk);
`ifdef PS_TRAP_EN
    check("ovf_pm", pm_addr, 'hF0); check("ovf_trap", trap, 1);
`else
    check("ovf_pm", pm_addr, 'h40); check("ovf_trap", trap, 0);
`endif
    nxt(); @(negedge clk); check("ovf_flag", stack_ovf, 1); check("ovf_sp", sp, 4);
    nxt(); err_clr = 1;
    nxt(); @(negedge clk); check("ovf_clr", stack_ovf, 0);
    for (int i = 0; i < 4; i++) begin nxt(); ret = 1; end

    // Underflow at pc=0x20
    nxt(); seg(1, 4'h2); jmp = 1;
    nxt(); ret = 1;
    @(negedge clk);
`ifdef PS_TRAP_EN
    check("unf_pm", pm_addr, 'hF0); check("unf_trap", trap, 1);
`else
    check("unf_pm", pm_addr, 'h21); check("unf_trap", trap, 0);
`endif
    nxt(); @(negedge clk); check("unf_flag", stack_unf, 1); check("unf_sp", sp, 0);
    nxt(); err_clr = 1;
    nxt(); @(negedge clk); check("unf_clr", stack_unf, 0);

    // Conditional jump
    nxt(); seg(1, 4'h6); jmp = 1;
    nxt(); jmp_nz = 1; dont_jmp = 1;
    @(negedge clk); check("jnz_not_taken", pm_addr, 'h61);
    nxt(); jmp_nz = 1;
    @(negedge clk); check("jnz_taken", pm_addr, 'h60);

    // Simultaneous call and ret
    nxt(); call = 1;
    nxt(); call = 1; ret = 1;
    @(negedge clk); check("callret_pm", pm_addr, 'h61);
    nxt(); @(negedge clk); check("callret_sp", sp, 0);

    // Address wrap
    nxt(); seg(0, 4'hF);
    nxt(); seg(1, 4'hF); jmp = 1;
    @(negedge clk); check("wrap_ff", pm_addr, 'hFF);
    nxt(); @(negedge clk); check("wrap_00", pm_addr, 'h00);

    // Two-cycle stall with jmp held
    nxt(); seg(0, 4'h3);
    nxt(); seg(1, 4'h3); jmp = 1;
    @(negedge clk); check("stall_setup", pm_addr, 'h33);
    nxt(); stall = 1; jmp = 1; seg(1, 4'h8);
    @(negedge clk); check("stall1_pm", pm_addr, 'h33);
    nxt(); stall = 1; jmp = 1;
    @(negedge clk); check("stall2_pm", pm_addr, 'h33); check("stall2_pc", pc, 'h33);
    nxt(); jmp = 1;
    @(negedge clk); check("stall_release", pm_addr, 'h83);

    // Reset in the middle of stack use
    nxt(); call = 1;
    nxt(); call = 1;
    nxt();
    @(negedge clk); check("pre_rst_sp", sp, 2);
    @(posedge clk); #1; reset_n = 0; #1;
    check("midrst_pm", pm_addr, 0); check("midrst_sp", sp, 0); check("midrst_pc", pc, 0);
    nxt(); reset_n = 1;
    @(negedge clk); check("restart_pm0", pm_addr, 0);
    nxt(); @(negedge clk); check("restart_pm1", pm_addr, 1); check("restart_sp", sp, 0);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
